// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the multicycle accumulator CPU.
// Opcode constants and the 2-bit FSM state encoding.
package acc_cpu_pkg;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_MEM    = 2'd2,
        S_WB     = 2'd3
    } state_t;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU.
// Ports: op (opcode), a (ACC), b (MDR) -> result, carry_out, zero_out.
// LDA passes b through; carry_out is only meaningful for ADD/SUB.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          carry_out,
    output logic          zero_out
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        // bit DW of the extended difference is the borrow (a < b)
        diff = {1'b0, a} - {1'b0, b};
        result    = b;
        carry_out = 1'b0;
        case (op)
            OP_ADD:  {carry_out, result} = sum;
            OP_SUB:  {carry_out, result} = diff;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = b;
        endcase
        zero_out = (result == '0);
    end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multicycle accumulator CPU with req/ack instruction and data ports.
// Ports: clk, rst (async, active-high); i_req/i_addr/i_ack/i_rdata fetch port;
// d_req/d_we/d_addr/d_wdata/d_ack/d_rdata data port;
// acc_out, pc_out, zero, carry status; retire pulses once per instruction.
module acc_cpu_mc
    import acc_cpu_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    output logic          i_req,
    output logic [AW-1:0] i_addr,
    input  logic          i_ack,
    input  logic [AW+2:0] i_rdata,
    output logic          d_req,
    output logic          d_we,
    output logic [AW-1:0] d_addr,
    output logic [DW-1:0] d_wdata,
    input  logic          d_ack,
    input  logic [DW-1:0] d_rdata,
    output logic [DW-1:0] acc_out,
    output logic [AW-1:0] pc_out,
    output logic          zero,
    output logic          carry,
    output logic          retire
);

    localparam int IW = 3 + AW;

    state_t        state;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic [IW-1:0] ir;
    logic [DW-1:0] mdr;

    logic [2:0]    op;
    logic [AW-1:0] opa;
    logic          is_branch;
    logic          take_jump;
    logic          is_sta;

    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_z;

    assign op        = ir[IW-1:AW];
    assign opa       = ir[AW-1:0];
    assign is_branch = (op == OP_JMP) || (op == OP_JZ);
    assign take_jump = (op == OP_JMP) || (op == OP_JZ && zero);
    assign is_sta    = (op == OP_STA);

    acc_cpu_alu #(.DW(DW)) u_alu (
        .op        (op),
        .a         (acc),
        .b         (mdr),
        .result    (alu_res),
        .carry_out (alu_c),
        .zero_out  (alu_z)
    );

    // Strobes decode from the state register; gating with rst drops a
    // pending request the moment reset is asserted.
    assign i_req   = !rst && (state == S_FETCH);
    assign d_req   = !rst && (state == S_MEM);
    assign d_we    = d_req && is_sta;
    assign i_addr  = pc;
    assign d_addr  = opa;
    assign d_wdata = acc;
    assign acc_out = acc;
    assign pc_out  = pc;

    assign retire = !rst && (
        (state == S_DECODE && is_branch) ||
        (state == S_MEM && is_sta && d_ack) ||
        (state == S_WB));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= '0;
            acc   <= '0;
            ir    <= '0;
            mdr   <= '0;
            zero  <= 1'b1;
            carry <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (i_ack) begin
                        ir    <= i_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_branch) begin
                        pc    <= take_jump ? opa : pc + 1'b1;
                        state <= S_FETCH;
                    end else begin
                        state <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (d_ack) begin
                        if (is_sta) begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end else begin
                            mdr   <= d_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    acc  <= alu_res;
                    zero <= alu_z;
                    if (op == OP_ADD || op == OP_SUB)
                        carry <= alu_c;
                    pc    <= pc + 1'b1;
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Testbench for acc_cpu_mc: wait-state memory models, an instruction-level
// reference model, directed corner sequences and a random program run.
module tb_acc_cpu_mc;

    localparam logic [2:0] LDA = 3'b000;
    localparam logic [2:0] STA = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;
    localparam logic [2:0] ANDO = 3'b100;
    localparam logic [2:0] XORO = 3'b101;
    localparam logic [2:0] JMP = 3'b110;
    localparam logic [2:0] JZ  = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_req;
    logic [4:0] i_addr;
    logic       i_ack = 1'b0;
    logic [7:0] i_rdata = 8'h00;
    logic       d_req;
    logic       d_we;
    logic [4:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_ack = 1'b0;
    logic [7:0] d_rdata = 8'h00;
    logic [7:0] acc_out;
    logic [4:0] pc_out;
    logic       zero;
    logic       carry;
    logic       retire;

    acc_cpu_mc #(.DW(8), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .acc_out(acc_out), .pc_out(pc_out), .zero(zero), .carry(carry),
        .retire(retire)
    );

    initial forever #5 clk = ~clk;

    logic [7:0] imem [32];
    logic [7:0] dmem [32];
    int  vecs = 0;
    int  errs = 0;
    int  wtot = 0;
    int  i_wait_fix = 0;
    int  d_wait_fix = 0;
    int  wait_max = 0;
    bit  noise_en = 0;
    bit  resp_en = 1;
    bit  man_ack = 0;
    logic [7:0] man_rdata = 8'h00;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a0;
        logic [7:0] m;
        logic [7:0] acc;
        logic       c;
        logic       z;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Memory models: a request is acked after a fixed or random number
    // of wait cycles; with noise on, idle ack lines toggle randomly.
    task automatic responder();
        int icnt = -1;
        int dcnt = -1;
        forever begin
            @(posedge clk);
            #2;
            if (!resp_en) begin
                i_ack = man_ack;
                i_rdata = man_rdata;
                d_ack = 1'b0;
                icnt = -1;
                dcnt = -1;
            end else begin
                if (i_req) begin
                    if (icnt < 0)
                        icnt = (i_wait_fix >= 0) ? i_wait_fix
                             : int'($urandom_range(wait_max, 0));
                    if (icnt == 0) begin
                        i_ack = 1'b1;
                        i_rdata = imem[i_addr];
                        icnt = -1;
                    end else begin
                        i_ack = 1'b0;
                        i_rdata = 8'($urandom);
                        icnt--;
                        wtot++;
                    end
                end else begin
                    icnt = -1;
                    i_ack = noise_en ? 1'($urandom) : 1'b0;
                    i_rdata = 8'($urandom);
                end
                if (d_req) begin
                    if (dcnt < 0)
                        dcnt = (d_wait_fix >= 0) ? d_wait_fix
                             : int'($urandom_range(wait_max, 0));
                    if (dcnt == 0) begin
                        d_ack = 1'b1;
                        if (d_we) dmem[d_addr] = d_wdata;
                        d_rdata = dmem[d_addr];
                        dcnt = -1;
                    end else begin
                        d_ack = 1'b0;
                        d_rdata = 8'($urandom);
                        dcnt--;
                        wtot++;
                    end
                end else begin
                    dcnt = -1;
                    d_ack = noise_en ? 1'($urandom) : 1'b0;
                    d_rdata = 8'($urandom);
                end
            end
        end
    endtask

    // Instruction-level reference: executes one instruction per retire
    // and checks architectural state and latency afterwards.
    task automatic model();
        logic [7:0] macc;
        logic [7:0] m;
        logic [7:0] ins;
        logic [7:0] mdm [32];
        logic [4:0] mpc;
        logic [4:0] a;
        logic [4:0] pa;
        logic [2:0] op;
        logic       mz;
        logic       mc;
        int  s;
        int  cyc = 0;
        int  last = 0;
        int  wlast = 0;
        int  base;
        bit  pend = 0;
        bit  pst = 0;
        macc = 0; mpc = 0; mz = 1; mc = 0; pa = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                macc = 8'h00; mpc = 5'd0; mz = 1'b1; mc = 1'b0;
                mdm = dmem;
                cyc = 0; last = 0; wlast = wtot;
                pend = 0; pst = 0;
            end else begin
                cyc++;
                if (i_req && d_req) chk("req_excl", 32'(d_req), 32'(0));
                if (pend) begin
                    chk("m_acc", 32'(acc_out), 32'(macc));
                    chk("m_pc", 32'(pc_out), 32'(mpc));
                    chk("m_zero", 32'(zero), 32'(mz));
                    chk("m_carry", 32'(carry), 32'(mc));
                    if (pst) chk("m_store", 32'(dmem[pa]), 32'(mdm[pa]));
                    pend = 0;
                    pst = 0;
                end
                if (retire) begin
                    ins = imem[mpc];
                    op = ins[7:5];
                    a = ins[4:0];
                    m = mdm[a];
                    base = (op == STA) ? 3 : (op == JMP || op == JZ) ? 2 : 4;
                    chk("m_latency", 32'(cyc - last), 32'(base + wtot - wlast));
                    last = cyc;
                    wlast = wtot;
                    case (op)
                        LDA: macc = m;
                        STA: begin mdm[a] = macc; pa = a; pst = 1; end
                        ADD: begin
                            s = int'(macc) + int'(m);
                            mc = (s > 255);
                            macc = 8'(s);
                        end
                        SUB: begin
                            mc = (macc < m);
                            macc = 8'(int'(macc) - int'(m) + 256);
                        end
                        ANDO: macc = macc & m;
                        XORO: macc = macc ^ m;
                        default: ;
                    endcase
                    if (op != STA && op != JMP && op != JZ) mz = (macc == 0);
                    if (op == JMP || (op == JZ && mz)) mpc = a;
                    else mpc = 5'(int'(mpc) + 1);
                    pend = 1;
                end
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            imem[i] = {JMP, 5'd0};
            dmem[i] = 8'h00;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Wait for the next retire; returns its cycle count and leaves the
    // bench just after the edge that commits the instruction.
    task automatic step(output int lat);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!retire && c < 40);
        if (!retire) chk("retire_timeout", 32'(retire), 32'(1));
        lat = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        fork
            responder();
            model();
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        tbl[0]  = '{ADD,  8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
        tbl[1]  = '{SUB,  8'd44,  8'd50,  8'd250, 1'b1, 1'b0};
        tbl[2]  = '{SUB,  8'd77,  8'd77,  8'd0,   1'b0, 1'b1};
        tbl[3]  = '{ADD,  8'd255, 8'd1,   8'd0,   1'b1, 1'b1};
        tbl[4]  = '{ADD,  8'd15,  8'd16,  8'd31,  1'b0, 1'b0};
        tbl[5]  = '{ANDO, 8'hF0,  8'h0F,  8'h00,  1'b0, 1'b1};
        tbl[6]  = '{ANDO, 8'hC3,  8'h81,  8'h81,  1'b0, 1'b0};
        tbl[7]  = '{XORO, 8'hAA,  8'h55,  8'hFF,  1'b0, 1'b0};
        tbl[8]  = '{XORO, 8'h3C,  8'h3C,  8'h00,  1'b0, 1'b1};
        tbl[9]  = '{LDA,  8'h7E,  8'h00,  8'h00,  1'b0, 1'b1};
        tbl[10] = '{SUB,  8'd0,   8'd1,   8'hFF,  1'b1, 1'b0};

        // reset state and zero-wait LDA
        clear_mem();
        imem[0] = {LDA, 5'd3};
        dmem[3] = 8'h5A;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_i_req", 32'(i_req), 32'(0));
        chk("rst_d_req", 32'(d_req), 32'(0));
        chk("rst_d_we", 32'(d_we), 32'(0));
        chk("rst_retire", 32'(retire), 32'(0));
        chk("rst_pc", 32'(pc_out), 32'(0));
        chk("rst_acc", 32'(acc_out), 32'(0));
        chk("rst_zero", 32'(zero), 32'(1));
        chk("rst_carry", 32'(carry), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("lda_i_req", 32'(i_req), 32'(k == 1));
            chk("lda_retire", 32'(retire), 32'(k == 4));
        end
        @(posedge clk);
        #1;
        chk("lda_acc", 32'(acc_out), 32'h5A);
        chk("lda_zero", 32'(zero), 32'(0));
        chk("lda_pc", 32'(pc_out), 32'(1));

        // ALU table with random wait states and ack noise
        wait_max = 2; i_wait_fix = -1; d_wait_fix = -1; noise_en = 1;
        for (int i = 0; i < 11; i++) begin
            clear_mem();
            imem[0] = {LDA, 5'd1};
            imem[1] = {tbl[i].op, 5'd2};
            imem[2] = {JMP, 5'd2};
            dmem[1] = tbl[i].a0;
            dmem[2] = tbl[i].m;
            do_reset(2);
            step(lat);
            step(lat);
            chk("tbl_acc", 32'(acc_out), 32'(tbl[i].acc));
            chk("tbl_carry", 32'(carry), 32'(tbl[i].c));
            chk("tbl_zero", 32'(zero), 32'(tbl[i].z));
        end

        // carry survives LDA after ADD/SUB chain
        clear_mem();
        imem[0] = {LDA, 5'd1};
        imem[1] = {ADD, 5'd4};
        imem[2] = {SUB, 5'd5};
        imem[3] = {LDA, 5'd6};
        dmem[1] = 8'd200; dmem[4] = 8'd100; dmem[5] = 8'd50; dmem[6] = 8'd0;
        do_reset(2);
        step(lat);
        step(lat);
        chk("chain_add_acc", 32'(acc_out), 32'd44);
        chk("chain_add_c", 32'(carry), 32'(1));
        step(lat);
        chk("chain_sub_acc", 32'(acc_out), 32'd250);
        chk("chain_sub_c", 32'(carry), 32'(1));
        step(lat);
        chk("chain_lda_z", 32'(zero), 32'(1));
        chk("chain_lda_c", 32'(carry), 32'(1));

        // STA with three data wait states
        noise_en = 0; i_wait_fix = 0; d_wait_fix = 3;
        clear_mem();
        imem[0] = {LDA, 5'd1};
        imem[1] = {STA, 5'd7};
        imem[2] = {JMP, 5'd2};
        dmem[1] = 8'hC3;
        do_reset(2);
        step(lat);
        chk("sta_lda_lat", 32'(lat), 32'(7));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("sta_d_req", 32'(d_req), 32'(k >= 3));
            chk("sta_retire", 32'(retire), 32'(k == 6));
            if (k >= 3) begin
                chk("sta_d_we", 32'(d_we), 32'(1));
                chk("sta_d_addr", 32'(d_addr), 32'(7));
                chk("sta_d_wdata", 32'(d_wdata), 32'hC3);
            end
        end
        @(posedge clk);
        #1;
        chk("sta_mem", 32'(dmem[7]), 32'hC3);

        // branches
        d_wait_fix = 0;
        clear_mem();
        imem[0] = {LDA, 5'd1};
        imem[1] = {JZ, 5'd10};
        imem[2] = {LDA, 5'd2};
        imem[3] = {JZ, 5'd10};
        imem[10] = {JMP, 5'd0};
        dmem[1] = 8'd5;
        do_reset(2);
        step(lat);
        step(lat);
        chk("jz_nt_lat", 32'(lat), 32'(2));
        chk("jz_nt_pc", 32'(pc_out), 32'(2));
        step(lat);
        step(lat);
        chk("jz_t_lat", 32'(lat), 32'(2));
        chk("jz_t_pc", 32'(pc_out), 32'(10));
        step(lat);
        chk("jmp_lat", 32'(lat), 32'(2));
        chk("jmp_pc", 32'(pc_out), 32'(0));

        // PC wrap from 31
        clear_mem();
        imem[0] = {JMP, 5'd31};
        imem[31] = {ADD, 5'd4};
        dmem[4] = 8'd1;
        do_reset(2);
        step(lat);
        chk("wrap_pc31", 32'(pc_out), 32'(31));
        step(lat);
        chk("wrap_pc", 32'(pc_out), 32'(0));
        chk("wrap_acc", 32'(acc_out), 32'(1));
        @(negedge clk);
        chk("wrap_i_addr", 32'(i_addr), 32'(0));

        // reset in the middle of a fetch, then a late ack
        clear_mem();
        imem[0] = {LDA, 5'd3};
        dmem[3] = 8'h5A;
        man_ack = 0;
        resp_en = 0;
        do_reset(2);
        @(negedge clk);
        chk("mid_i_req_before", 32'(i_req), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("mid_i_req_async", 32'(i_req), 32'(0));
        man_rdata = {ADD, 5'd31};
        man_ack = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        man_ack = 0;
        chk("mid_acc", 32'(acc_out), 32'(0));
        chk("mid_pc", 32'(pc_out), 32'(0));
        chk("mid_zero", 32'(zero), 32'(1));
        repeat (2) @(posedge clk);
        resp_en = 1;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_restart_req", 32'(i_req), 32'(1));
        chk("mid_restart_addr", 32'(i_addr), 32'(0));
        step(lat);
        chk("mid_lat", 32'(lat), 32'(3));
        chk("mid_acc_after", 32'(acc_out), 32'h5A);

        // random programs against the reference model
        wait_max = 2; i_wait_fix = -1; d_wait_fix = -1; noise_en = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) begin
                imem[i] = 8'($urandom);
                dmem[i] = 8'($urandom);
            end
            do_reset(2);
            for (int n = 0; n < 150; n++) step(lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
